// File: rtl/uart_rx_if.sv
// uart_rx_if: control, serial input and holding-register signals between the UART register block and the receive front-end
interface uart_rx_if;
  logic       rx_en;
  logic [1:0] baud_sel;
  logic       rx;
  logic       rx_ack;
  logic [7:0] rx_data;
  logic       rx_full;
  logic       rx_done;
  logic       frame_err;
  logic       overrun;
  modport master (output rx_en, baud_sel, rx, rx_ack, input rx_data, rx_full, rx_done, frame_err, overrun);
  modport slave (input rx_en, baud_sel, rx, rx_ack, output rx_data, rx_full, rx_done, frame_err, overrun);
endinterface

// File: rtl/uart_rx_frontend.sv
// uart_rx_frontend: 16x-oversampled UART receiver with majority-voted bits and a one-byte holding register
module uart_rx_frontend #(
  parameter int DIV_01 = 52,
  parameter int DIV_10 = 35,
  parameter int DIV_11 = 17
) (
  input logic      clk,
  input logic      rst,
  uart_rx_if.slave bus
);
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;
  state_t     state, state_d;
  logic       r1, rxs, rxs_d;
  logic [5:0] div_q, cnt;
  logic [3:0] s;
  logic [2:0] b, v;
  logic [7:0] sh;
  logic       ok, fall, tick, maj, maj9, good, ferr;
  assign ok   = bus.rx_en && bus.baud_sel != 2'b00;
  assign fall = rxs_d && !rxs;
  assign tick = state != IDLE && cnt == div_q - 6'd1;
  assign maj  = (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
  assign maj9 = (v[0] & v[1]) | (v[0] & rxs) | (v[1] & rxs);
  assign good = ok && state == STOP && tick && s == 4'd9 && maj9;
  assign ferr = ok && state == STOP && tick && s == 4'd9 && !maj9;
  // two-flop pin synchroniser plus one flop of history for start-edge detection
  always_ff @(posedge clk)
    {r1, rxs, rxs_d} <= rst ? 3'b111 : {bus.rx, r1, rxs};
  // state register
  always_ff @(posedge clk)
    state <= rst ? IDLE : state_d;
  // next-state: stop is judged at mid-bit so the next start edge is never missed
  always_comb begin
    state_d = state;
    case (state)
      IDLE:    state_d = fall ? START : IDLE;
      START:   if (tick && s == 4'd15) state_d = maj ? IDLE : DATA;
      DATA:    if (tick && s == 4'd15 && b == 3'd7) state_d = STOP;
      STOP:    if (tick && s == 4'd9) state_d = maj9 ? IDLE : BREAK;
      BREAK:   if (rxs) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (!ok) state_d = IDLE;
  end
  // tick/sample counters, 3-sample vote capture and LSB-first shift register; divisor frozen outside IDLE
  always_ff @(posedge clk) begin
    if (rst) begin
      div_q <= 6'd0;
      cnt   <= 6'd0;
      s     <= 4'd0;
      b     <= 3'd0;
      v     <= 3'd0;
      sh    <= 8'd0;
    end else begin
      if (state == IDLE)
        div_q <= bus.baud_sel == 2'b01 ? 6'(DIV_01) : bus.baud_sel == 2'b10 ? 6'(DIV_10) : 6'(DIV_11);
      cnt <= (state == IDLE || state_d == IDLE || tick) ? 6'd0 : cnt + 6'd1;
      s   <= state == IDLE ? 4'd0 : tick ? s + 4'd1 : s;
      if (tick)
        v <= s == 4'd7 ? {v[2:1], rxs} : s == 4'd8 ? {v[2], rxs, v[0]} : s == 4'd9 ? {rxs, v[1:0]} : v;
      if (tick && s == 4'd15 && state == START)
        b <= 3'd0;
      if (tick && s == 4'd15 && state == DATA) begin
        sh <= {maj, sh[7:1]};
        b  <= b + 3'd1;
      end
    end
  end
  // holding register and sticky flags; an ack in the same cycle as a load suppresses overrun
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.rx_data   <= 8'h00;
      bus.rx_full   <= 1'b0;
      bus.rx_done   <= 1'b0;
      bus.frame_err <= 1'b0;
      bus.overrun   <= 1'b0;
    end else begin
      bus.rx_data   <= good ? sh : bus.rx_data;
      bus.rx_full   <= good | (bus.rx_full & ~bus.rx_ack);
      bus.rx_done   <= good;
      bus.frame_err <= ferr | (bus.frame_err & ~bus.rx_ack);
      bus.overrun   <= (good & bus.rx_full & ~bus.rx_ack) | (bus.overrun & ~bus.rx_ack);
    end
  end
endmodule
